// File: rtl/mips_lsu.sv
// Load/store unit between the MIPS core and the data cache: big-endian byte lanes,
// sign/zero-extended loads, read-modify-write sub-word stores, misalign and timeout errors.
module mips_lsu #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              stall,
    output logic              cache_en,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_write_en,
    output logic [XLEN-1:0]   cache_wdata,
    input  logic [XLEN-1:0]   cache_rdata,
    input  logic              cache_hit
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRmwRd,
        StWr,
        StResp,
        StErr
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  wait_q;
    logic              write_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   cache_wdata_q;
    logic [XLEN-1:0]   rdata_q;

    logic req_misaligned;
    logic req_full;

    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            default: req_misaligned = (XLEN == 32) || (|req_addr[2:0]);
        endcase
        req_full = (XLEN == 32) ? (req_size == 2'b10) : (req_size == 2'b11);
    end

    // Lane datapath on the latched request; only meaningful for aligned accesses.
    int unsigned     lane_bytes;
    int unsigned     lane_shift;
    logic            lane_full;
    logic            lane_msb;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] lane_raw;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] store_merge;

    always_comb begin
        lane_bytes = 32'd1 << size_q;
        if (lane_bytes > BYTES) begin
            lane_bytes = BYTES;
        end
        lane_full  = (lane_bytes == BYTES);
        lane_shift = 8 * (BYTES - lane_bytes - 32'(addr_q[OFF_W-1:0]));
        case (size_q)
            2'b00:   lane_mask = XLEN'(8'hFF);
            2'b01:   lane_mask = XLEN'(16'hFFFF);
            2'b10:   lane_mask = XLEN'(32'hFFFF_FFFF);
            default: lane_mask = '1;
        endcase
        lane_raw = (cache_rdata >> lane_shift) & lane_mask;
        case (size_q)
            2'b00:   lane_msb = lane_raw[7];
            2'b01:   lane_msb = lane_raw[15];
            default: lane_msb = lane_raw[31];
        endcase
        load_ext = lane_raw;
        if (signed_q && lane_msb && !lane_full) begin
            load_ext = lane_raw | ~lane_mask;
        end
        store_merge = (cache_rdata & ~(lane_mask << lane_shift))
                    | ((wdata_q & lane_mask) << lane_shift);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= StIdle;
            wait_q        <= '0;
            write_q       <= 1'b0;
            signed_q      <= 1'b0;
            size_q        <= 2'b00;
            addr_q        <= '0;
            wdata_q       <= '0;
            cache_wdata_q <= '0;
            rdata_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                        wait_q   <= '0;
                        if (req_misaligned) begin
                            state_q <= StErr;
                        end else if (!req_write) begin
                            state_q <= StRd;
                        end else if (req_full) begin
                            cache_wdata_q <= req_wdata;
                            state_q       <= StWr;
                        end else begin
                            state_q <= StRmwRd;
                        end
                    end
                end
                StRd, StRmwRd: begin
                    if (cache_hit) begin
                        if (state_q == StRd) begin
                            rdata_q <= load_ext;
                            state_q <= StResp;
                        end else begin
                            cache_wdata_q <= store_merge;
                            wait_q        <= '0;
                            state_q       <= StWr;
                        end
                    end else if (wait_q == CNT_W'(MAX_WAIT)) begin
                        state_q <= StErr;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                StWr: begin
                    if (cache_hit) begin
                        state_q <= StResp;
                    end else if (wait_q == CNT_W'(MAX_WAIT)) begin
                        state_q <= StErr;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                StResp, StErr: state_q <= StIdle;
                default:       state_q <= StIdle;
            endcase
        end
    end

    logic busy;
    assign busy = (state_q == StRd) || (state_q == StRmwRd) || (state_q == StWr);

    assign req_ready      = (state_q == StIdle);
    assign stall          = ((state_q == StIdle) && req_valid) || busy;
    assign cache_en       = busy;
    assign cache_write_en = (state_q == StWr);
    assign cache_addr     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign cache_wdata    = cache_wdata_q;
    assign resp_valid     = (state_q == StResp) || (state_q == StErr);
    assign resp_err       = (state_q == StErr);
    assign resp_rdata     = (state_q == StResp) ? rdata_q : '0;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: one XLEN=32 and one XLEN=64 instance (MAX_WAIT=4) against a byte-array
// memory model; directed cases first, then randomized requests.
module tb_mips_lsu;

    localparam int MW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic        req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        v32;
    logic        v64;
    assign v32 = req_valid & ~sel;
    assign v64 = req_valid & sel;

    logic        r32_ready, r32_valid, r32_err, s32_stall, c32_en, c32_we, c32_hit;
    logic [31:0] r32_rdata, c32_addr, c32_wdata, c32_rdata;
    logic        r64_ready, r64_valid, r64_err, s64_stall, c64_en, c64_we, c64_hit;
    logic [63:0] r64_rdata, c64_wdata, c64_rdata;
    logic [31:0] c64_addr;

    mips_lsu #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MW)) dut32 (
        .clk(clk), .rst_b(rst_b), .req_valid(v32), .req_ready(r32_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .resp_valid(r32_valid),
        .resp_err(r32_err), .resp_rdata(r32_rdata), .stall(s32_stall), .cache_en(c32_en),
        .cache_addr(c32_addr), .cache_write_en(c32_we), .cache_wdata(c32_wdata),
        .cache_rdata(c32_rdata), .cache_hit(c32_hit)
    );

    mips_lsu #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(MW)) dut64 (
        .clk(clk), .rst_b(rst_b), .req_valid(v64), .req_ready(r64_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r64_valid),
        .resp_err(r64_err), .resp_rdata(r64_rdata), .stall(s64_stall), .cache_en(c64_en),
        .cache_addr(c64_addr), .cache_write_en(c64_we), .cache_wdata(c64_wdata),
        .cache_rdata(c64_rdata), .cache_hit(c64_hit)
    );

    // Reference memory image (bytes, big-endian order by address) and the cache arrays.
    logic [7:0]  model32 [64];
    logic [7:0]  model64 [128];
    logic [31:0] mem32 [16];
    logic [63:0] mem64 [16];
    int          hit_delay;
    int          w32;
    int          w64;

    assign c32_rdata = mem32[c32_addr[5:2]];
    assign c64_rdata = mem64[c64_addr[6:3]];
    assign c32_hit   = c32_en && (w32 == hit_delay);
    assign c64_hit   = c64_en && (w64 == hit_delay);

    always @(posedge clk) begin
        if (!rst_b) begin
            w32 <= 0;
            w64 <= 0;
            for (int i = 0; i < 16; i++) begin
                mem32[i] <= {model32[4*i], model32[4*i+1], model32[4*i+2], model32[4*i+3]};
                mem64[i] <= {model64[8*i], model64[8*i+1], model64[8*i+2], model64[8*i+3],
                             model64[8*i+4], model64[8*i+5], model64[8*i+6], model64[8*i+7]};
            end
        end else begin
            w32 <= (!c32_en || c32_hit) ? 0 : w32 + 1;
            w64 <= (!c64_en || c64_hit) ? 0 : w64 + 1;
            if (c32_en && c32_we && c32_hit) mem32[c32_addr[5:2]] <= c32_wdata;
            if (c64_en && c64_we && c64_hit) mem64[c64_addr[6:3]] <= c64_wdata;
        end
    end

    logic        o_ready, o_valid, o_err, o_stall, o_en, o_we, o_hit;
    logic [63:0] o_rdata, o_cwdata;
    logic [31:0] o_caddr;
    assign o_ready  = sel ? r64_ready : r32_ready;
    assign o_valid  = sel ? r64_valid : r32_valid;
    assign o_err    = sel ? r64_err : r32_err;
    assign o_stall  = sel ? s64_stall : s32_stall;
    assign o_en     = sel ? c64_en : c32_en;
    assign o_we     = sel ? c64_we : c32_we;
    assign o_hit    = sel ? c64_hit : c32_hit;
    assign o_rdata  = sel ? r64_rdata : {32'h0, r32_rdata};
    assign o_cwdata = sel ? c64_wdata : {32'h0, c32_wdata};
    assign o_caddr  = sel ? c64_addr : c32_addr;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input bit x64, input logic [31:0] a);
        return x64 ? model64[a[6:0]] : model32[a[5:0]];
    endfunction

    task automatic do_op(input bit x64, input bit wr, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] addr, input logic [63:0] wd, input int dly);
        int          n, nb, exp_lat, cycles;
        bit          mis, tmo, sub, seen_en, got_wr, bad_hs;
        logic [63:0] exp_rd, exp_wd, got_wd;
        logic [31:0] base, got_caddr;
        nb      = x64 ? 8 : 4;
        n       = 1 << sz;
        mis     = (!x64 && sz == 2'b11) || ((int'(addr[2:0]) % n) != 0);
        tmo     = !mis && (dly > MW);
        sub     = wr && (n < nb);
        base    = addr & ~(32'(nb) - 32'd1);
        exp_rd  = '0;
        exp_wd  = '0;
        if (mis)      exp_lat = 1;
        else if (tmo) exp_lat = MW + 2;
        else if (sub) exp_lat = 3 + 2 * dly;
        else          exp_lat = 2 + dly;
        if (!mis && !tmo && !wr) begin
            for (int i = 0; i < n; i++) exp_rd = (exp_rd << 8) | 64'(mbyte(x64, addr + 32'(i)));
            if (sgn && n < nb && exp_rd[8*n-1]) exp_rd = exp_rd | ~((64'd1 << (8 * n)) - 64'd1);
            if (!x64) exp_rd[63:32] = '0;
        end
        if (!mis && !tmo && wr) begin
            for (int i = 0; i < n; i++) begin
                if (x64) model64[7'(addr + 32'(i))] = 8'(wd >> (8 * (n - 1 - i)));
                else     model32[6'(addr + 32'(i))] = 8'(wd >> (8 * (n - 1 - i)));
            end
            for (int i = 0; i < nb; i++) exp_wd = (exp_wd << 8) | 64'(mbyte(x64, base + 32'(i)));
        end

        hit_delay = dly;
        sel       = x64;
        @(negedge clk);
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        #1;
        check_eq("idle_ready", 64'(o_ready), 64'd1);
        check_eq("idle_stall", 64'(o_stall), 64'd1);
        @(posedge clk);
        #1;
        // Request fields must be ignored once accepted.
        req_write  = ~wr;
        req_size   = ~sz;
        req_signed = ~sgn;
        req_addr   = $urandom;
        req_wdata  = {$urandom, $urandom};
        cycles     = 0;
        seen_en    = 1'b0;
        got_wr     = 1'b0;
        bad_hs     = 1'b0;
        got_wd     = '0;
        got_caddr  = '0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (o_en) begin
                seen_en   = 1'b1;
                got_caddr = o_caddr;
            end
            if (o_en && o_we && o_hit) begin
                got_wr = 1'b1;
                got_wd = o_cwdata;
            end
            if (o_valid) break;
            if (!o_stall || o_ready) bad_hs = 1'b1;
        end
        check_eq("latency", 64'(cycles), 64'(exp_lat));
        check_eq("resp_err", 64'(o_err), 64'(mis || tmo));
        check_eq("resp_rdata", o_rdata, exp_rd);
        check_eq("resp_stall_ready", 64'({o_stall, o_ready}), 64'd0);
        check_eq("busy_handshake", 64'(bad_hs), 64'd0);
        if (mis) check_eq("err_no_cache", 64'(seen_en), 64'd0);
        else     check_eq("cache_addr", 64'(got_caddr), 64'(base));
        if (wr && !mis && !tmo) begin
            check_eq("wr_strobe", 64'(got_wr), 64'd1);
            check_eq("wr_data", got_wd, exp_wd);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        bit          x64, wr, sgn;
        logic [1:0]  sz;
        logic [31:0] addr;
        int          dly;
        rst_b      = 1'b0;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        hit_delay  = 0;
        for (int i = 0; i < 64; i++)  model32[i] = 8'($urandom);
        for (int i = 0; i < 128; i++) model64[i] = 8'($urandom);
        model32[0] = 8'h11;
        model32[1] = 8'hA2;
        model32[2] = 8'hB3;
        model32[3] = 8'hC4;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check_eq("rst_ready", 64'(o_ready), 64'd1);
            check_eq("rst_stall", 64'(o_stall), 64'd0);
            check_eq("rst_resp", 64'({o_valid, o_err}), 64'd0);
            check_eq("rst_rdata", o_rdata, 64'd0);
            check_eq("rst_cache", 64'({o_en, o_we}), 64'd0);
            check_eq("rst_caddr", 64'(o_caddr), 64'd0);
            check_eq("rst_cwdata", o_cwdata, 64'd0);
        end
        @(negedge clk);
        rst_b = 1'b1;

        // Loads from 0x100 = 11A2B3C4, first-cycle hit.
        do_op(1'b0, 1'b0, 2'b00, 1'b1, 32'h101, 64'h0, 0);
        check_eq("lb_const", o_rdata, 64'h0000_0000_FFFF_FFA2);
        do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h101, 64'h0, 0);
        do_op(1'b0, 1'b0, 2'b01, 1'b1, 32'h102, 64'h0, 0);
        check_eq("lh_const", o_rdata, 64'h0000_0000_FFFF_B3C4);
        do_op(1'b0, 1'b0, 2'b01, 1'b0, 32'h100, 64'h0, 0);
        do_op(1'b0, 1'b0, 2'b10, 1'b1, 32'h100, 64'h0, 0);
        // Sub-word store with a delayed hit, then read back.
        do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 64'hEE, 3);
        do_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 64'h0, 0);
        check_eq("sb_readback", o_rdata, 64'h0000_0000_11A2_B3EE);
        // Misaligned and reserved-size errors.
        do_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h102, 64'h0, 0);
        do_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h101, 64'h1234, 0);
        do_op(1'b0, 1'b0, 2'b11, 1'b0, 32'h100, 64'h0, 0);
        // Timeout, then hit exactly on the last allowed cycle.
        do_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h104, 64'h0, 99);
        do_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h104, 64'h0, MW);

        // Asynchronous reset in the middle of a never-completing write.
        sel       = 1'b0;
        hit_delay = 99;
        @(negedge clk);
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h104;
        req_wdata  = 64'hDEAD_BEEF;
        req_valid  = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_we", 64'({o_en, o_we}), 64'd3);
        rst_b     = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("midrst_cache", 64'({o_en, o_we}), 64'd0);
        check_eq("midrst_stall", 64'(o_stall), 64'd0);
        check_eq("midrst_ready", 64'(o_ready), 64'd1);
        check_eq("midrst_resp", 64'(o_valid), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        do_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h108, 64'h0, 0);

        for (int k = 0; k < 250; k++) begin
            x64  = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            addr = 32'h100 + 32'($urandom_range(0, x64 ? 127 : 63));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            dly  = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, MW));
            do_op(x64, wr, sz, sgn, addr, {$urandom, $urandom}, dly);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
Parametrised load/store unit between the MIPS core datapath and the data cache. It replaces the core's inline LB/SB byte-lane muxing and hit-gated PC stall with a dedicated FSM. The FSM supports byte, halfword, word and (XLEN=64) doubleword accesses, signed and unsigned loads, and read-modify-write sub-word stores. It also adds misalignment and cache-timeout error reporting. The core holds its PC while stall=1 and consumes the result on the resp_valid pulse.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64; BYTES = XLEN/8, OFF_W = log2(BYTES).
ADDR_W, 32, address width.
MAX_WAIT, 15, cache wait cycles per phase before timeout error; minimum 1.

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
req_valid  in  1  core presents a memory op; held until resp_valid
req_ready  out  1  LSU accepts a request this cycle
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when XLEN=64)
req_signed  in  1  loads: sign-extend when 1, zero-extend when 0
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: misaligned, reserved size, or timeout
resp_rdata  out  XLEN  extended load result; 0 for stores and errors
stall  out  1  core must hold PC
cache_en  out  1  cache access request
cache_addr  out  ADDR_W  aligned address (low OFF_W bits zero)
cache_write_en  out  1  cache write strobe
cache_wdata  out  XLEN  big-endian word (byte 0 in MSBs)
cache_rdata  in  XLEN  big-endian word from cache
cache_hit  in  1  cache access complete this cycle

Behaviour:
- States: IDLE, RD, RMW_RD, WR, RESP, ERR. Every output is registered or decoded from state plus latched request fields.
- Reset (async, any state): state=IDLE, wait counter=0, latched request=0. Outputs: req_ready=1, stall=0, resp_valid=0, resp_err=0, resp_rdata=0, cache_en=0, cache_write_en=0, cache_addr=0, cache_wdata=0.
- IDLE:
  - req_ready=1.
  - On req_valid the LSU latches write, size, signed, addr and wdata. Later changes to req_* are ignored until the next IDLE.
  - Misaligned access goes to ERR. Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; doubleword with addr[2:0]≠0; or size 11 when XLEN=32.
  - Otherwise: load goes to RD; store of full XLEN goes to WR with cache_wdata=wdata; sub-word store goes to RMW_RD.
- RD / RMW_RD:
  - cache_en=1, cache_write_en=0.
  - When cache_hit=1: RD goes to RESP with resp_rdata computed from cache_rdata. RMW_RD merges store bytes into cache_rdata, latches the result as cache_wdata, and goes to WR.
- WR:
  - cache_en=1, cache_write_en=1.
  - cache_hit=1 goes to RESP.
- Timeout: the wait counter clears on entry to RD, RMW_RD and WR, and increments each cycle without a hit. Counter == MAX_WAIT with no hit goes to ERR. A hit in the same cycle takes priority over the timeout.
- RESP: resp_valid=1, resp_err=0; next state IDLE.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0; next state IDLE. ERR issues no cache access.
- req_ready=0 in every state except IDLE. A new request is accepted no earlier than the IDLE cycle after RESP/ERR.
- stall=1 when (state==IDLE and req_valid) or state in {RD, RMW_RD, WR}. stall=0 in RESP and ERR so the core advances on that edge.
- Byte lanes (big-endian): byte k = addr[OFF_W-1:0] occupies bits [XLEN-1-8k -: 8]. Half at offset k occupies [XLEN-1-8k -: 16]; word likewise [XLEN-1-8k -: 32].
- Load extension: the lane is right-justified. Upper bits are filled with the lane MSB if signed, else 0. A full-XLEN load is passed through unchanged.
- Sub-word store: the low 8/16/32 bits of wdata replace the addressed lane. All other bytes keep cache_rdata.
- cache_hit outside RD/RMW_RD/WR is ignored.
- Latency: load or full-word store hitting on the first cache cycle asserts resp_valid 2 cycles after acceptance. A sub-word store hitting first cycle in both phases takes 3 cycles. Each wait cycle adds 1.

Test Plan:
1. XLEN=32, cache word at 0x100 = 0x11A2B3C4, hit on first cycle. LB signed at 0x101 → resp_rdata=0xFFFFFFA2, resp_valid exactly 2 cycles after acceptance; stall=1 for the accept and RD cycles only.
2. Same word: LBU at 0x101 → 0x000000A2; LH signed at 0x102 → 0xFFFFB3C4; LHU at 0x100 → 0x000011A2; LW at 0x100 → 0x11A2B3C4.
3. SB at 0x103, wdata=0x000000EE, hit delayed 3 cycles in RMW_RD → cache_wdata=0x11A2B3EE with cache_write_en=1 in WR. A following LW at 0x100 returns 0x11A2B3EE.
4. Misaligned requests: LW at 0x102 and SH at 0x101 → resp_valid=1 and resp_err=1 one cycle after acceptance; cache_en never asserted. Size 11 at XLEN=32 → same error response.
5. MAX_WAIT=4, cache_hit held 0 on LW → ERR after 5 RD cycles, resp_err=1, resp_rdata=0. Hit arriving on the counter==MAX_WAIT cycle instead → normal RESP.
6. Assert rst_b=0 mid-WR → state IDLE immediately, cache_en=0, cache_write_en=0, stall=0, req_ready=1. After release, XLEN=64 LD at 0x108 returns the full 64-bit word.
